// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network back end.
//   - Default sizing constants for the vote classifier (class count, packet
//     width, per-class counter width, image counter width).
//   - vc_state_e: the argmax FSM states of vote_classifier.
// No ports; imported by vote_classifier and vote_counter_bank.
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int DEFAULT_NUM_CLASSES  = 9;
  localparam int DEFAULT_PACKET_WIDTH = 8;
  localparam int DEFAULT_COUNT_WIDTH  = 16;
  localparam int IMG_COUNT_WIDTH      = 16;

  // ACCUM collects votes, SCAN walks the counters one per cycle looking for
  // the maximum, REPORT publishes the winner and clears the counters.
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } vc_state_e;

endpackage

// File: rtl/vote_counter_bank.sv
// -----------------------------------------------------------------------------
// vote_counter_bank
// Array of NUM_CLASSES saturating vote counters.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (zeroes all counters)
//   inc_en       : add one vote to counter inc_idx at the next clock edge
//   inc_idx      : class index to increment
//   clr          : zero every counter at the next clock edge (wins over inc_en)
//   rd_idx       : combinational read address
//   rd_data      : value of counter rd_idx (0 for out-of-range addresses)
//   sat_hit      : high when the requested increment hits a counter already
//                  at its maximum value (the counter stays put)
//   counts       : all counter values, only present when
//                  VOTE_CLASSIFIER_HIST_EN is defined (used for snapshots)
// -----------------------------------------------------------------------------
module vote_counter_bank
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inc_en,
  input  logic [$clog2(NUM_CLASSES)-1:0] inc_idx,
  input  logic                           clr,
  input  logic [$clog2(NUM_CLASSES)-1:0] rd_idx,
  output logic [COUNT_WIDTH-1:0]         rd_data,
  output logic                           sat_hit
`ifdef VOTE_CLASSIFIER_HIST_EN
  ,
  output logic [COUNT_WIDTH-1:0]         counts [NUM_CLASSES]
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] cnt_q [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_CLASSES];

  // Next counter values: a clear wipes the whole bank, otherwise only the
  // addressed counter moves, and it sticks at its maximum instead of wrapping.
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc_en && (int'(inc_idx) == i)) begin
        if (cnt_q[i] == CNT_MAX) begin
          sat_hit = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read mux written as a compare loop so an address past the last class
  // simply reads as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (int'(rd_idx) == i) begin
        rd_data = cnt_q[i];
      end
    end
  end

`ifdef VOTE_CLASSIFIER_HIST_EN
  // Expose every counter so the top level can snapshot a finished image.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      counts[i] = cnt_q[i];
    end
  end
`endif

endmodule

// File: rtl/vote_classifier.sv
// -----------------------------------------------------------------------------
// vote_classifier
// Accumulates spike packets from the grid output core as per-class votes,
// then at the end of each image scans the counters for the class with the
// most votes (lowest index wins ties) and reports it for one cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   packet_in       : spike packet; class = packet_in mod NUM_CLASSES
//   packet_in_valid : packet qualifier
//   img_done        : one-cycle end-of-image pulse
//   class_out       : winning class index (held until the next report)
//   max_votes       : vote count of the winning class (held likewise)
//   class_valid     : one-cycle pulse marking a new report
//   busy            : high while scanning or reporting
//   img_count       : number of images reported, wraps at 16 bits
//   drop_err        : sticky, a packet arrived while not accumulating
//   sat_err         : sticky, a vote hit a counter already at its maximum
// Optional (macro VOTE_CLASSIFIER_HIST_EN):
//   hist_addr       : class index into the last reported image's counters
//   hist_data       : registered read of that snapshot, one-cycle latency
// -----------------------------------------------------------------------------
module vote_classifier
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES  = DEFAULT_NUM_CLASSES,
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PACKET_WIDTH-1:0]        packet_in,
  input  logic                           packet_in_valid,
  input  logic                           img_done,
  output logic [$clog2(NUM_CLASSES)-1:0] class_out,
  output logic [COUNT_WIDTH-1:0]         max_votes,
  output logic                           class_valid,
  output logic                           busy,
  output logic [IMG_COUNT_WIDTH-1:0]     img_count,
  output logic                           drop_err,
  output logic                           sat_err
`ifdef VOTE_CLASSIFIER_HIST_EN
  ,
  input  logic [$clog2(NUM_CLASSES)-1:0] hist_addr,
  output logic [COUNT_WIDTH-1:0]         hist_data
`endif
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  vc_state_e                  state_q, state_d;
  logic [IDX_W-1:0]           scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]           best_idx_q, best_idx_d;
  logic [COUNT_WIDTH-1:0]     best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]           class_out_q, class_out_d;
  logic [COUNT_WIDTH-1:0]     max_votes_q, max_votes_d;
  logic                       class_valid_q, class_valid_d;
  logic [IMG_COUNT_WIDTH-1:0] img_count_q, img_count_d;
  logic                       drop_err_q, drop_err_d;
  logic                       sat_err_q, sat_err_d;

  logic                       inc_en;
  logic                       clr_cnt;
  logic [IDX_W-1:0]           pkt_class;
  logic [COUNT_WIDTH-1:0]     rd_data;
  logic                       sat_hit;
  logic [IDX_W-1:0]           cand_idx;
  logic [COUNT_WIDTH-1:0]     cand_cnt;

`ifdef VOTE_CLASSIFIER_HIST_EN
  logic [COUNT_WIDTH-1:0]     counts [NUM_CLASSES];
`endif

  // Class of the incoming packet; the modulus is a constant so this folds
  // into a small fixed mapping.
  assign pkt_class = IDX_W'(32'(packet_in) % 32'(NUM_CLASSES));

  vote_counter_bank #(
    .NUM_CLASSES (NUM_CLASSES),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (inc_en),
    .inc_idx (pkt_class),
    .clr     (clr_cnt),
    .rd_idx  (scan_idx_q),
    .rd_data (rd_data),
    .sat_hit (sat_hit)
`ifdef VOTE_CLASSIFIER_HIST_EN
    ,
    .counts  (counts)
`endif
  );

  // Next-state and datapath control. Votes land in the counters at the edge
  // that samples them, so a packet arriving alongside img_done is already
  // visible when scan cycle 0 reads counter 0. The final scan cycle loads the
  // result registers directly, which makes them valid during the REPORT cycle
  // itself; the counter clear and image count update share that same edge.
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    best_idx_d    = best_idx_q;
    best_cnt_d    = best_cnt_q;
    class_out_d   = class_out_q;
    max_votes_d   = max_votes_q;
    class_valid_d = 1'b0;
    img_count_d   = img_count_q;
    drop_err_d    = drop_err_q;
    sat_err_d     = sat_err_q;
    inc_en        = 1'b0;
    clr_cnt       = 1'b0;
    cand_idx      = best_idx_q;
    cand_cnt      = best_cnt_q;

    if (packet_in_valid) begin
      if (state_q == ST_ACCUM) begin
        inc_en = 1'b1;
      end else begin
        drop_err_d = 1'b1;
      end
    end

    if (sat_hit) begin
      sat_err_d = 1'b1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (img_done) begin
          state_d    = ST_SCAN;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end
      end
      ST_SCAN: begin
        // Strictly-greater replacement keeps the earliest (lowest) index on
        // ties; starting from zero means an empty image reports class 0.
        if (rd_data > best_cnt_q) begin
          cand_idx = scan_idx_q;
          cand_cnt = rd_data;
        end
        best_idx_d = cand_idx;
        best_cnt_d = cand_cnt;
        if (scan_idx_q == LAST_IDX) begin
          state_d       = ST_REPORT;
          class_out_d   = cand_idx;
          max_votes_d   = cand_cnt;
          class_valid_d = 1'b1;
          img_count_d   = img_count_q + IMG_COUNT_WIDTH'(1);
          clr_cnt       = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and result registers; reset aborts any scan in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ACCUM;
      scan_idx_q    <= '0;
      best_idx_q    <= '0;
      best_cnt_q    <= '0;
      class_out_q   <= '0;
      max_votes_q   <= '0;
      class_valid_q <= 1'b0;
      img_count_q   <= '0;
      drop_err_q    <= 1'b0;
      sat_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      best_idx_q    <= best_idx_d;
      best_cnt_q    <= best_cnt_d;
      class_out_q   <= class_out_d;
      max_votes_q   <= max_votes_d;
      class_valid_q <= class_valid_d;
      img_count_q   <= img_count_d;
      drop_err_q    <= drop_err_d;
      sat_err_q     <= sat_err_d;
    end
  end

  assign class_out   = class_out_q;
  assign max_votes   = max_votes_q;
  assign class_valid = class_valid_q;
  assign busy        = (state_q != ST_ACCUM);
  assign img_count   = img_count_q;
  assign drop_err    = drop_err_q;
  assign sat_err     = sat_err_q;

`ifdef VOTE_CLASSIFIER_HIST_EN
  logic [COUNT_WIDTH-1:0] snap_q [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0] snap_d [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0] hist_data_q, hist_data_d;

  // The snapshot is taken on the same edge that clears the counters, so it
  // captures the counts of the image being reported.
  always_comb begin
    hist_data_d = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      snap_d[i] = clr_cnt ? counts[i] : snap_q[i];
      if (int'(hist_addr) == i) begin
        hist_data_d = snap_q[i];
      end
    end
  end

  // Snapshot storage and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        snap_q[i] <= '0;
      end
      hist_data_q <= '0;
    end else begin
      snap_q      <= snap_d;
      hist_data_q <= hist_data_d;
    end
  end

  assign hist_data = hist_data_q;
`endif

endmodule

// File: tb/tb_vote_classifier.sv
// -----------------------------------------------------------------------------
// tb_vote_classifier
// Drives two vote_classifier instances with the same stimulus: one with the
// default 16-bit counters and one with 4-bit counters so saturation is easy
// to reach. A cycle-scheduled model of the expected outputs is checked
// against both instances every cycle, and directed scenarios pin specific
// hand-computed results.
// -----------------------------------------------------------------------------
module tb_vote_classifier;

  localparam int NC = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  packet_in;
  logic        packet_in_valid;
  logic        img_done;

  logic [3:0]  class_out_a, class_out_b;
  logic [15:0] max_votes_a;
  logic [3:0]  max_votes_b;
  logic        class_valid_a, class_valid_b;
  logic        busy_a, busy_b;
  logic [15:0] img_count_a, img_count_b;
  logic        drop_err_a, drop_err_b;
  logic        sat_err_a, sat_err_b;

  int testsRun    = 0;
  int testsFailed = 0;

  vote_classifier dut_a (
    .clk             (clk),
    .rst             (rst),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .img_done        (img_done),
    .class_out       (class_out_a),
    .max_votes       (max_votes_a),
    .class_valid     (class_valid_a),
    .busy            (busy_a),
    .img_count       (img_count_a),
    .drop_err        (drop_err_a),
    .sat_err         (sat_err_a)
  );

  vote_classifier #(.COUNT_WIDTH(4)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .img_done        (img_done),
    .class_out       (class_out_b),
    .max_votes       (max_votes_b),
    .class_valid     (class_valid_b),
    .busy            (busy_b),
    .img_count       (img_count_b),
    .drop_err        (drop_err_b),
    .sat_err         (sat_err_b)
  );

  always #5 clk = ~clk;

  // Shared comparison helper used by both the per-cycle checker and the
  // directed scenarios.
  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: votes are plain per-class tallies; an accepted
  // img_done picks the winner immediately and schedules its publication
  // NC edges later, with input locked out until one edge after that.
  int m_cnt [2][NC];
  int m_lim [2] = '{65535, 15};
  int m_class [2], m_max [2], m_pendClass [2], m_pendMax [2];
  int m_sat [2];
  int m_drop = 0, m_img = 0;
  int edgeNo = 0, lockUntil = -1, repEdge = -1;
  int cls, best, bestIdx;
  bit accepting;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_class[k] = 0; m_max[k] = 0; m_sat[k] = 0;
      m_pendClass[k] = 0; m_pendMax[k] = 0;
      for (int i = 0; i < NC; i++) m_cnt[k][i] = 0;
    end
  end

  // Model update at each rising edge, then a check of both instances once
  // their registers have settled.
  always @(posedge clk) begin
    edgeNo++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NC; i++) m_cnt[k][i] = 0;
        m_class[k] = 0; m_max[k] = 0; m_sat[k] = 0;
      end
      m_drop = 0; m_img = 0; lockUntil = -1; repEdge = -1;
    end else begin
      accepting = (edgeNo > lockUntil);
      if (packet_in_valid) begin
        if (accepting) begin
          cls = int'(packet_in) % NC;
          for (int k = 0; k < 2; k++) begin
            if (m_cnt[k][cls] >= m_lim[k]) m_sat[k] = 1;
            else m_cnt[k][cls]++;
          end
        end else begin
          m_drop = 1;
        end
      end
      if (img_done && accepting) begin
        for (int k = 0; k < 2; k++) begin
          best = 0; bestIdx = 0;
          for (int i = 0; i < NC; i++) begin
            if (m_cnt[k][i] > best) begin
              best = m_cnt[k][i]; bestIdx = i;
            end
          end
          m_pendClass[k] = bestIdx; m_pendMax[k] = best;
          for (int i = 0; i < NC; i++) m_cnt[k][i] = 0;
        end
        repEdge   = edgeNo + NC;
        lockUntil = edgeNo + NC + 1;
      end
      if (edgeNo == repEdge) begin
        for (int k = 0; k < 2; k++) begin
          m_class[k] = m_pendClass[k]; m_max[k] = m_pendMax[k];
        end
        m_img = (m_img + 1) % 65536;
      end
    end
    #2;
    checkOutput($sformatf("a.class_valid@%0d", edgeNo), int'(class_valid_a), int'(edgeNo == repEdge));
    checkOutput($sformatf("b.class_valid@%0d", edgeNo), int'(class_valid_b), int'(edgeNo == repEdge));
    checkOutput($sformatf("a.busy@%0d", edgeNo), int'(busy_a), int'(edgeNo < lockUntil));
    checkOutput($sformatf("b.busy@%0d", edgeNo), int'(busy_b), int'(edgeNo < lockUntil));
    checkOutput($sformatf("a.img_count@%0d", edgeNo), int'(img_count_a), m_img);
    checkOutput($sformatf("b.img_count@%0d", edgeNo), int'(img_count_b), m_img);
    checkOutput($sformatf("a.drop_err@%0d", edgeNo), int'(drop_err_a), m_drop);
    checkOutput($sformatf("b.drop_err@%0d", edgeNo), int'(drop_err_b), m_drop);
    checkOutput($sformatf("a.sat_err@%0d", edgeNo), int'(sat_err_a), m_sat[0]);
    checkOutput($sformatf("b.sat_err@%0d", edgeNo), int'(sat_err_b), m_sat[1]);
    checkOutput($sformatf("a.class_out@%0d", edgeNo), int'(class_out_a), m_class[0]);
    checkOutput($sformatf("b.class_out@%0d", edgeNo), int'(class_out_b), m_class[1]);
    checkOutput($sformatf("a.max_votes@%0d", edgeNo), int'(max_votes_a), m_max[0]);
    checkOutput($sformatf("b.max_votes@%0d", edgeNo), int'(max_votes_b), m_max[1]);
  end

  // One input cycle: drive on the falling edge, return at the next falling
  // edge after the rising edge has sampled it.
  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic d);
    packet_in_valid = v;
    packet_in       = p;
    img_done        = d;
    @(negedge clk);
  endtask

  // Idle until class_valid shows on the default instance, counting cycles
  // from the img_done edge; a missing report is a failed comparison.
  task automatic waitReport(input int startLat, output int lat);
    lat = startLat;
    while (!class_valid_a && lat < 30) begin
      applyStimulus(1'b0, 8'd0, 1'b0);
      lat++;
    end
    checkOutput("report_seen", int'(class_valid_a), 1);
  endtask

  int lat;

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1; packet_in_valid = 1'b0; packet_in = 8'd0; img_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_class_out", int'(class_out_a), 0);
    checkOutput("rst_max_votes", int'(max_votes_a), 0);
    checkOutput("rst_img_count", int'(img_count_a), 0);
    checkOutput("rst_busy", int'(busy_a), 0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Packets 0,9,18 vote class 0 three times; 4,13 vote class 4 twice.
    applyStimulus(1'b1, 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b0);
    applyStimulus(1'b1, 8'd18, 1'b0);
    applyStimulus(1'b1, 8'd4, 1'b0);
    applyStimulus(1'b1, 8'd13, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitReport(0, lat);
    checkOutput("s1_latency", lat, 9);
    checkOutput("s1_class_out", int'(class_out_a), 0);
    checkOutput("s1_max_votes", int'(max_votes_a), 3);
    checkOutput("s1_img_count", int'(img_count_a), 1);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("s1_valid_pulse_ends", int'(class_valid_a), 0);
    checkOutput("s1_class_held", int'(class_out_a), 0);

    // Tie between classes 2 and 7 goes to the lower index; a second img_done
    // during the scan is ignored.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(2 + 9 * i), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(7 + 9 * i), 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitReport(1, lat);
    checkOutput("s2_latency", lat, 9);
    checkOutput("s2_class_out", int'(class_out_a), 2);
    checkOutput("s2_max_votes", int'(max_votes_a), 5);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Empty image.
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitReport(0, lat);
    checkOutput("s3_class_out", int'(class_out_a), 0);
    checkOutput("s3_max_votes", int'(max_votes_a), 0);
    checkOutput("s3_img_count", int'(img_count_a), 3);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Packet with img_done counts; the one during SCAN is dropped.
    checkOutput("s4_drop_before", int'(drop_err_a), 0);
    applyStimulus(1'b1, 8'd8, 1'b1);
    applyStimulus(1'b1, 8'd1, 1'b0);
    waitReport(1, lat);
    checkOutput("s4_class_out", int'(class_out_a), 8);
    checkOutput("s4_max_votes", int'(max_votes_a), 1);
    checkOutput("s4_drop_err", int'(drop_err_a), 1);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Twenty votes for class 3: the 4-bit instance saturates at 15.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitReport(0, lat);
    checkOutput("s5_a_max_votes", int'(max_votes_a), 20);
    checkOutput("s5_a_sat_err", int'(sat_err_a), 0);
    checkOutput("s5_b_class_out", int'(class_out_b), 3);
    checkOutput("s5_b_max_votes", int'(max_votes_b), 15);
    checkOutput("s5_b_sat_err", int'(sat_err_b), 1);
    applyStimulus(1'b0, 8'd0, 1'b0);

    // Reset in scan cycle 4 aborts the report; the next image is normal.
    applyStimulus(1'b1, 8'd5, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    repeat (4) applyStimulus(1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s6_rst_valid", int'(class_valid_a), 0);
    checkOutput("s6_rst_busy", int'(busy_a), 0);
    checkOutput("s6_rst_img_count", int'(img_count_a), 0);
    checkOutput("s6_rst_class_out", int'(class_out_a), 0);
    checkOutput("s6_rst_max_votes", int'(max_votes_a), 0);
    checkOutput("s6_rst_drop_err", int'(drop_err_a), 0);
    checkOutput("s6_rst_sat_err_b", int'(sat_err_b), 0);
    rst = 1'b0;
    repeat (12) applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("s6_no_late_report", int'(img_count_a), 0);
    applyStimulus(1'b1, 8'd6, 1'b0);
    applyStimulus(1'b1, 8'd6, 1'b0);
    applyStimulus(1'b1, 8'd15, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    waitReport(0, lat);
    checkOutput("s6_latency", lat, 9);
    checkOutput("s6_class_out", int'(class_out_a), 6);
    checkOutput("s6_max_votes", int'(max_votes_a), 3);
    checkOutput("s6_img_count", int'(img_count_a), 1);
    repeat (3) applyStimulus(1'b0, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
